// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - dual-lane issue scoreboard with busy vector and A-before-B split issue
module issue_scoreboard #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   flush_i,
    input  logic                   A_valid_i,
    input  logic [4:0]             A_rs1_addr_i,
    input  logic                   A_rs1_use_i,
    input  logic [4:0]             A_rs2_addr_i,
    input  logic                   A_rs2_use_i,
    input  logic [4:0]             A_rd_addr_i,
    input  logic                   A_rd_write_i,
    input  logic                   B_valid_i,
    input  logic [4:0]             B_rs1_addr_i,
    input  logic                   B_rs1_use_i,
    input  logic [4:0]             B_rs2_addr_i,
    input  logic                   B_rs2_use_i,
    input  logic [4:0]             B_rd_addr_i,
    input  logic                   B_rd_write_i,
    input  logic                   A_wb_valid_i,
    input  logic [4:0]             A_wb_addr_i,
    input  logic                   B_wb_valid_i,
    input  logic [4:0]             B_wb_addr_i,
    output logic                   A_issue_o,
    output logic                   B_issue_o,
    output logic                   pair_accept_o,
    output logic                   split_o,
    output logic [31:0]            busy_o,
    output logic [STALL_CNT_W-1:0] stall_count_o
);

    typedef enum logic {
        PAIR    = 1'b0,
        SPLIT_B = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [31:0]            busy;
    logic [31:0]            busy_next;
    logic [31:0]            wb_clear;
    logic [31:0]            live_busy;
    logic [31:0]            issue_set;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic                   a_blocked;
    logic                   b_blocked;
    logic                   intra_dep;
    logic                   a_issue;
    logic                   b_issue;
    logic                   accept;
    logic                   stall_inc;

    always_comb begin
        wb_clear = '0;
        if (A_wb_valid_i) wb_clear[A_wb_addr_i] = 1'b1;
        if (B_wb_valid_i) wb_clear[B_wb_addr_i] = 1'b1;
    end

    // A writeback landing this cycle satisfies readers: the regfile captures read addresses on the write edge.
    assign live_busy = busy & ~wb_clear & 32'hFFFF_FFFE;

    assign a_blocked = (A_rs1_use_i  && live_busy[A_rs1_addr_i]) ||
                       (A_rs2_use_i  && live_busy[A_rs2_addr_i]) ||
                       (A_rd_write_i && live_busy[A_rd_addr_i]);

    assign b_blocked = (B_rs1_use_i  && live_busy[B_rs1_addr_i]) ||
                       (B_rs2_use_i  && live_busy[B_rs2_addr_i]) ||
                       (B_rd_write_i && live_busy[B_rd_addr_i]);

    assign intra_dep = A_rd_write_i && (A_rd_addr_i != 5'd0) &&
                       ((B_rs1_use_i  && (B_rs1_addr_i == A_rd_addr_i)) ||
                        (B_rs2_use_i  && (B_rs2_addr_i == A_rd_addr_i)) ||
                        (B_rd_write_i && (B_rd_addr_i  == A_rd_addr_i)));

    always_comb begin
        state_next = state;
        a_issue    = 1'b0;
        b_issue    = 1'b0;
        accept     = 1'b0;
        if (flush_i) begin
            state_next = PAIR;
        end else begin
            case (state)
                PAIR: begin
                    if (A_valid_i) begin
                        if (!a_blocked) begin
                            a_issue = 1'b1;
                            if (!B_valid_i) begin
                                accept = 1'b1;
                            end else if (!b_blocked && !intra_dep) begin
                                b_issue = 1'b1;
                                accept  = 1'b1;
                            end else begin
                                state_next = SPLIT_B;
                            end
                        end
                    end else if (B_valid_i) begin
                        b_issue = !b_blocked;
                        accept  = !b_blocked;
                    end else begin
                        accept = 1'b1;
                    end
                end
                SPLIT_B: begin
                    // Lane A already issued; its rd is busy, so B waits on writeback like any RAW.
                    if (!B_valid_i) begin
                        accept     = 1'b1;
                        state_next = PAIR;
                    end else if (!b_blocked) begin
                        b_issue    = 1'b1;
                        accept     = 1'b1;
                        state_next = PAIR;
                    end
                end
                default: state_next = PAIR;
            endcase
        end
    end

    always_comb begin
        issue_set = '0;
        if (a_issue && A_rd_write_i) issue_set[A_rd_addr_i] = 1'b1;
        if (b_issue && B_rd_write_i) issue_set[B_rd_addr_i] = 1'b1;
    end

    // Set after clear so a fresh issue survives a same-cycle writeback of the old value.
    assign busy_next = ((busy & ~wb_clear) | issue_set) & 32'hFFFF_FFFE;

    assign stall_inc = (A_valid_i || B_valid_i || (state == SPLIT_B)) &&
                       !a_issue && !b_issue && !flush_i;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= PAIR;
            busy      <= '0;
            stall_cnt <= '0;
        end else begin
            if (flush_i) begin
                state <= PAIR;
                busy  <= '0;
            end else begin
                state <= state_next;
                busy  <= busy_next;
            end
            if (stall_inc && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);
            end
        end
    end

    assign A_issue_o     = a_issue;
    assign B_issue_o     = b_issue;
    assign pair_accept_o = accept;
    assign split_o       = (state == SPLIT_B);
    assign busy_o        = busy;
    assign stall_count_o = stall_cnt;

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - randomized and directed self-checking bench for issue_scoreboard
module tb_issue_scoreboard;
    localparam int SW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush;
    logic          valid [2];
    logic          u1 [2];
    logic          u2 [2];
    logic          wr [2];
    logic [4:0]    a1 [2];
    logic [4:0]    a2 [2];
    logic [4:0]    rd [2];
    logic          wbv [2];
    logic [4:0]    wba [2];
    logic          a_issue, b_issue, accept, split;
    logic [31:0]   busy;
    logic [SW-1:0] stall;

    bit [31:0] m_busy;
    bit        m_split;
    int        m_stall;
    int        tests = 0;
    int        fails = 0;

    always #5 clk = ~clk;

    issue_scoreboard #(.STALL_CNT_W(SW)) dut (
        .clock_i(clk), .reset_i(rst), .flush_i(flush),
        .A_valid_i(valid[0]), .A_rs1_addr_i(a1[0]), .A_rs1_use_i(u1[0]),
        .A_rs2_addr_i(a2[0]), .A_rs2_use_i(u2[0]), .A_rd_addr_i(rd[0]), .A_rd_write_i(wr[0]),
        .B_valid_i(valid[1]), .B_rs1_addr_i(a1[1]), .B_rs1_use_i(u1[1]),
        .B_rs2_addr_i(a2[1]), .B_rs2_use_i(u2[1]), .B_rd_addr_i(rd[1]), .B_rd_write_i(wr[1]),
        .A_wb_valid_i(wbv[0]), .A_wb_addr_i(wba[0]), .B_wb_valid_i(wbv[1]), .B_wb_addr_i(wba[1]),
        .A_issue_o(a_issue), .B_issue_o(b_issue), .pair_accept_o(accept),
        .split_o(split), .busy_o(busy), .stall_count_o(stall)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit reg_hazard(int r);
        if (r == 0) return 1'b0;
        for (int l = 0; l < 2; l++)
            if (wbv[l] && int'(wba[l]) == r) return 1'b0;
        return m_busy[r];
    endfunction

    function automatic bit lane_ok(int l);
        int need[$];
        if (u1[l]) need.push_back(int'(a1[l]));
        if (u2[l]) need.push_back(int'(a2[l]));
        if (wr[l]) need.push_back(int'(rd[l]));
        foreach (need[i]) if (reg_hazard(need[i])) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit pair_dep();
        int touched[$];
        if (!wr[0] || rd[0] == 5'd0) return 1'b0;
        if (u1[1]) touched.push_back(int'(a1[1]));
        if (u2[1]) touched.push_back(int'(a2[1]));
        if (wr[1]) touched.push_back(int'(rd[1]));
        foreach (touched[i]) if (touched[i] == int'(rd[0])) return 1'b1;
        return 1'b0;
    endfunction

    // Returns {A issue, B issue, accept} for the present inputs and model state.
    function automatic bit [2:0] expect_out();
        bit ea = 0, eb = 0, acc = 0;
        if (flush) return 3'b000;
        if (m_split) begin
            eb  = valid[1] && lane_ok(1);
            acc = eb || !valid[1];
        end else if (valid[0]) begin
            ea = lane_ok(0);
            if (ea) begin
                if (!valid[1]) acc = 1;
                else if (lane_ok(1) && !pair_dep()) begin eb = 1; acc = 1; end
            end
        end else if (valid[1]) begin
            eb  = lane_ok(1);
            acc = eb;
        end else begin
            acc = 1;
        end
        return {ea, eb, acc};
    endfunction

    function automatic bit [31:0] next_busy(bit ea, bit eb);
        bit [31:0] n = m_busy;
        for (int l = 0; l < 2; l++) if (wbv[l]) n[wba[l]] = 1'b0;
        if (ea && wr[0]) n[rd[0]] = 1'b1;
        if (eb && wr[1]) n[rd[1]] = 1'b1;
        n[0] = 1'b0;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin : model_upd
        bit [2:0] e;
        if (rst) begin
            m_busy  <= '0;
            m_split <= 1'b0;
            m_stall <= 0;
        end else begin
            e = expect_out();
            if ((valid[0] || valid[1] || m_split) && !e[2] && !e[1] && !flush && m_stall < (1 << SW) - 1)
                m_stall <= m_stall + 1;
            if (flush) begin
                m_busy  <= '0;
                m_split <= 1'b0;
            end else begin
                m_busy  <= next_busy(e[2], e[1]);
                m_split <= m_split ? !e[0] : (e[2] && valid[1] && !e[1]);
            end
        end
    end

    always @(negedge clk) begin : compare
        bit [2:0] e;
        if (!rst) begin
            e = expect_out();
            chk("a_issue", a_issue, e[2]);
            chk("b_issue", b_issue, e[1]);
            chk("accept", accept, e[0]);
            chk("split", split, m_split);
            chk("busy", busy, m_busy);
            chk("stall", stall, m_stall);
        end
    end

    task automatic clear_in();
        flush = 0;
        for (int l = 0; l < 2; l++) begin
            valid[l] = 0; u1[l] = 0; u2[l] = 0; wr[l] = 0;
            a1[l] = 0; a2[l] = 0; rd[l] = 0; wbv[l] = 0; wba[l] = 0;
        end
    endtask

    task automatic set_lane(input int l, input bit v, input int s1, input bit us1,
                            input int s2, input bit us2, input int d, input bit w);
        valid[l] = v; a1[l] = 5'(s1); u1[l] = us1; a2[l] = 5'(s2); u2[l] = us2;
        rd[l] = 5'(d); wr[l] = w;
    endtask

    task automatic set_wb(input int l, input bit v, input int addr);
        wbv[l] = v; wba[l] = 5'(addr);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_all();
        for (int r = 1; r <= 31; r += 2) begin
            clear_in();
            set_lane(0, 1, 0, 0, 0, 0, r, 1);
            if (r < 31) set_lane(1, 1, 0, 0, 0, 0, r + 1, 1);
            step();
        end
        clear_in();
        chk("fill_busy", busy, 32'hFFFF_FFFE);
        set_lane(0, 1, 0, 0, 0, 0, 1, 1);
        set_wb(0, 1, 1);
        set_lane(1, 1, 2, 1, 0, 0, 0, 0);
        step();
        set_wb(0, 0, 0);
        chk("split_set", split, 1'b1);
        chk("split_busy", busy, 32'hFFFF_FFFE);
    endtask

    initial begin
        clear_in();
        rst = 1;
        #7;
        chk("rst_busy", busy, 32'h0);
        chk("rst_split", split, 1'b0);
        chk("rst_stall", stall, '0);
        chk("rst_accept", accept, 1'b1);
        @(negedge clk) rst = 0;
        step();

        set_lane(0, 1, 2, 1, 0, 0, 1, 1);
        set_lane(1, 1, 4, 1, 0, 0, 3, 1);
        @(negedge clk);
        chk("ind_a", a_issue, 1'b1); chk("ind_b", b_issue, 1'b1); chk("ind_acc", accept, 1'b1);
        step();
        chk("ind_busy", busy, 32'h0000_000A);
        clear_in(); set_wb(0, 1, 1); set_wb(1, 1, 3);
        step();
        chk("ind_clr", busy, 32'h0);

        clear_in();
        set_lane(0, 1, 6, 1, 0, 0, 5, 1);
        set_lane(1, 1, 5, 1, 0, 0, 8, 1);
        @(negedge clk);
        chk("raw_a", a_issue, 1'b1); chk("raw_b0", b_issue, 1'b0); chk("raw_acc0", accept, 1'b0);
        step();
        chk("raw_split", split, 1'b1); chk("raw_busy", busy, 32'h0000_0020);
        @(negedge clk);
        chk("raw_hold", b_issue, 1'b0);
        step();
        set_wb(0, 1, 5);
        @(negedge clk);
        chk("raw_b1", b_issue, 1'b1); chk("raw_acc1", accept, 1'b1);
        step();
        clear_in();
        chk("raw_pair", split, 1'b0); chk("raw_busy2", busy, 32'h0000_0100);
        set_wb(1, 1, 8);
        step();
        clear_in();

        set_lane(0, 1, 0, 0, 0, 0, 7, 1);
        step();
        clear_in();
        chk("b7_busy", busy, 32'h0000_0080);
        set_lane(0, 1, 7, 1, 0, 0, 10, 1);
        set_lane(1, 1, 12, 1, 0, 0, 11, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("b7_noissue", a_issue | b_issue, 1'b0);
            step();
            chk("b7_stall", stall, SW'(2 + k));
        end
        set_wb(0, 1, 7);
        @(negedge clk);
        chk("b7_both", {a_issue, b_issue, accept}, 3'b111);
        step();
        clear_in();
        chk("b7_busy2", busy, 32'h0000_0C00);
        set_wb(0, 1, 10); set_wb(1, 1, 11);
        step();
        clear_in();

        set_lane(0, 1, 1, 1, 0, 0, 0, 1);
        set_lane(1, 1, 0, 1, 0, 0, 13, 1);
        @(negedge clk);
        chk("x0_both", {a_issue, b_issue, accept}, 3'b111);
        step();
        clear_in();
        chk("x0_busy", busy, 32'h0000_2000);
        set_wb(1, 1, 13);
        step();
        clear_in();

        set_lane(0, 1, 0, 0, 0, 0, 9, 1);
        step();
        chk("sw_busy0", busy, 32'h0000_0200);
        set_wb(1, 1, 9);
        @(negedge clk);
        chk("sw_a", a_issue, 1'b1);
        step();
        clear_in();
        chk("sw_busy1", busy, 32'h0000_0200);
        chk("sw_stall", stall, SW'(4));
        set_wb(0, 1, 9);
        step();
        clear_in();

        fill_all();
        flush = 1;
        @(negedge clk);
        chk("fl_out", {a_issue, b_issue, accept}, 3'b000);
        step();
        flush = 0;
        chk("fl_busy", busy, 32'h0);
        chk("fl_split", split, 1'b0);
        clear_in();

        fill_all();
        #2 rst = 1;
        #1;
        chk("ar_busy", busy, 32'h0);
        chk("ar_split", split, 1'b0);
        chk("ar_stall", stall, '0);
        clear_in();
        @(negedge clk) rst = 0;
        step();

        set_lane(0, 1, 0, 0, 0, 0, 20, 1);
        step();
        set_lane(0, 1, 20, 1, 0, 0, 21, 1);
        repeat (70) step();
        chk("sat_stall", stall, {SW{1'b1}});
        flush = 1;
        step();
        clear_in();

        repeat (3000) begin
            if (!m_split) begin
                for (int l = 0; l < 2; l++) begin
                    valid[l] = ($urandom_range(0, 9) < 8);
                    a1[l] = 5'($urandom_range(0, 7)); u1[l] = 1'($urandom_range(0, 1));
                    a2[l] = 5'($urandom_range(0, 7)); u2[l] = 1'($urandom_range(0, 1));
                    rd[l] = 5'($urandom_range(0, 7)); wr[l] = 1'($urandom_range(0, 1));
                end
            end
            for (int l = 0; l < 2; l++) begin
                wbv[l] = 1'($urandom_range(0, 1));
                wba[l] = 5'($urandom_range(0, 7));
            end
            flush = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
